// File: rtl/bcd_xs3_seq_ctrl.sv
// Sequencing controller: converts a packed BCD word to Excess-3 one digit per
// clock through a shared external 4-bit converter, with per-digit error flags.
module bcd_xs3_seq_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [4*NDIG-1:0] bcd_in,
    output logic [3:0]        conv_b,
    input  logic [3:0]        conv_x,
    output logic [4*NDIG-1:0] xs3_out,
    output logic [NDIG-1:0]   err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NDIG-1:0][3:0]   opnd_q, opnd_d;
    logic [NDIG-1:0][3:0]   xs3_q, xs3_d;
    logic [NDIG-1:0]        err_q, err_d;
    logic [3:0]             dig;

    assign dig = opnd_q[cnt_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opnd_q  <= '0;
            xs3_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opnd_q  <= opnd_d;
            xs3_q   <= xs3_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opnd_d  = opnd_q;
        xs3_d   = xs3_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    state_d = CONV;
                    opnd_d  = bcd_in;
                    xs3_d   = '0;
                    err_d   = '0;
                    cnt_d   = '0;
                end
            end
            CONV: begin
                // Non-BCD digits are forced to zero regardless of the converter.
                if (dig > 4'd9) begin
                    xs3_d[cnt_q] = 4'b0000;
                    err_d[cnt_q] = 1'b1;
                end else begin
                    xs3_d[cnt_q] = conv_x;
                end
                if (cnt_q == LAST) state_d = DONE;
                else               cnt_d   = cnt_q + CW'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state_q == IDLE);
        busy        = (state_q == CONV) || (state_q == DONE);
        out_valid   = (state_q == DONE);
        conv_b      = (state_q == CONV) ? dig : 4'b0000;
        xs3_out     = xs3_q;
        err         = err_q;
    end
endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// Bench for bcd_xs3_seq_ctrl: vector table, hand-written corner sequences and
// randomized jobs checked against a digit-wise BCD+3 reference model.
module tb_bcd_xs3_seq_ctrl;
    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_valid = 1'b0;
    logic            start_ready;
    logic [4*ND-1:0] bcd_in = '0;
    logic [3:0]      conv_b;
    logic [3:0]      conv_x;
    logic [4*ND-1:0] xs3_out;
    logic [ND-1:0]   err;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Shared converter: plain BCD+3, also for non-BCD codes (A gives D).
    assign conv_x = conv_b + 4'd3;

    bcd_xs3_seq_ctrl #(.NDIG(ND)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .bcd_in(bcd_in), .conv_b(conv_b), .conv_x(conv_x), .xs3_out(xs3_out),
        .err(err), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] xs3;
        logic [3:0]  err;
        int          hold;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model(input logic [15:0] b, output logic [15:0] x, output logic [3:0] e);
        x = '0;
        e = '0;
        for (int k = 0; k < ND; k++) begin
            int d;
            d = int'(b[4*k +: 4]);
            if (d > 9) e[k] = 1'b1;
            else       x[4*k +: 4] = 4'(d + 3);
        end
    endfunction

    task automatic start_job(input logic [15:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!start_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("start_ready_wait", {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        bcd_in      = b;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic collect(input logic [15:0] b);
        logic [15:0] seq;
        int lat;
        seq = '0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            chk("busy_in_conv", {31'd0, busy}, 32'd1);
            seq = {conv_b, seq[15:4]};
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, ND);
        chk("conv_b_seq", {16'd0, seq}, {16'd0, b});
    endtask

    task automatic finish_job(input int hold, input logic [15:0] xe, input logic [3:0] ee);
        chk("xs3_out", {16'd0, xs3_out}, {16'd0, xe});
        chk("err", {28'd0, err}, {28'd0, ee});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_xs3", {16'd0, xs3_out}, {16'd0, xe});
            chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", {31'd0, out_valid}, 32'd0);
        chk("post_start_ready", {31'd0, start_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic run_job(input logic [15:0] b, input logic [15:0] xe, input logic [3:0] ee,
                           input int hold);
        start_job(b);
        collect(b);
        finish_job(hold, xe, ee);
    endtask

    vec_t tbl[5];
    int acc[3];
    int n;
    int bad;
    logic [15:0] rb, rx;
    logic [3:0] re;

    initial begin
        tbl[0] = '{16'h1234, 16'h4567, 4'b0000, 0};
        tbl[1] = '{16'h0999, 16'h3CCC, 4'b0000, 0};
        tbl[2] = '{16'h9A05, 16'hC038, 4'b0100, 0};
        tbl[3] = '{16'hFFFF, 16'h0000, 4'b1111, 1};
        tbl[4] = '{16'h9876, 16'hCBA9, 4'b0000, 2};

        #12;
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_xs3", {16'd0, xs3_out}, 32'd0);
        chk("rst_err", {28'd0, err}, 32'd0);
        chk("rst_conv_b", {28'd0, conv_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_job(tbl[i].bcd, tbl[i].xs3, tbl[i].err, tbl[i].hold);

        // Backpressure with a start request arriving during DONE.
        start_job(16'h5678);
        collect(16'h5678);
        chk("bp_first_xs3", {16'd0, xs3_out}, 32'h89AB);
        start_valid = 1'b1;
        bcd_in      = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_xs3", {16'd0, xs3_out}, 32'h89AB);
            chk("bp_hold_start_ready", {31'd0, start_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_idle_after", {31'd0, start_ready}, 32'd1);
        chk("bp_valid_after", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1 start_valid = 1'b0;
        collect(16'h1111);
        finish_job(0, 16'h4444, 4'b0000);

        // Reset in the middle of a conversion.
        start_job(16'h4321);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_conv_b", {28'd0, conv_b}, 32'h3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_conv_b", {28'd0, conv_b}, 32'd0);
        chk("mid_rst_xs3", {16'd0, xs3_out}, 32'd0);
        chk("mid_rst_err", {28'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        chk("no_valid_after_rst", bad, 0);
        run_job(16'h0000, 16'h3333, 4'b0000, 0);

        // Back-to-back jobs with both handshakes held high.
        @(negedge clk);
        out_ready   = 1'b1;
        bcd_in      = 16'h2468;
        start_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            if (start_valid && start_ready) begin
                acc[n] = i;
                n++;
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        chk("b2b_accepts", n, 3);
        if (n == 3) begin
            chk("b2b_gap1", acc[1] - acc[0], ND + 2);
            chk("b2b_gap2", acc[2] - acc[1], ND + 2);
        end
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_xs3", {16'd0, xs3_out}, 32'h579B);
        chk("b2b_idle", {31'd0, start_ready}, 32'd1);

        // Randomized jobs against the reference model.
        for (int i = 0; i < 25; i++) begin
            rb = 16'($urandom);
            if (i % 2 == 0)
                for (int k = 0; k < ND; k++) rb[4*k +: 4] = 4'($urandom_range(0, 9));
            model(rb, rx, re);
            run_job(rb, rx, re, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_xs3_seq_ctrl.md
# bcd_xs3_seq_ctrl

Sequencing controller that converts a multi-digit packed BCD word to Excess-3 by time-sharing a single combinational 4-bit BCD-to-XS-3 converter, one digit per clock. The block sits between a requester (valid/ready input handshake) and a consumer (valid/ready output handshake). It drives the shared converter's digit input, captures its result into a per-digit result register, and flags non-BCD digits.

## Interface
- NDIG, default 4: number of BCD digits per job (NDIG ≥ 1); counter width is clog2(NDIG), minimum 1.
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: reset is asynchronous and active-low.
- start_valid, input, 1: requester has a job on bcd_in.
- start_ready, output, 1: block can accept a job. High only in IDLE.
- bcd_in, input, 4*NDIG: packed BCD; digit k = bcd_in[4k+3:4k], digit 0 is least significant.
- conv_b, output, 4: digit presented to the shared converter.
- conv_x, input, 4: converter result for conv_b, combinational, same cycle.
- xs3_out, output, 4*NDIG: packed XS-3 result; digit k = xs3_out[4k+3:4k].
- err, output, NDIG: per-digit flag; bit k set means digit k was greater than 9.
- out_valid, output, 1: xs3_out and err are valid.
- out_ready, input, 1: consumer accepts the result.
- busy, output, 1: high in CONV or DONE.

## Operation
- States:
  - IDLE: start_ready=1.
  - CONV: convert digit cnt, cnt = 0..NDIG-1.
  - DONE: out_valid=1.
- IDLE → CONV on start_valid & start_ready.
  - Latch bcd_in into the operand register.
  - Clear xs3_out and err to 0; cnt ← 0.
- CONV, every cycle:
  - conv_b = operand digit cnt.
  - If the digit is ≤ 9, result digit cnt ← conv_x. Otherwise result digit cnt ← 4'b0000 and err[cnt] ← 1, independent of conv_x.
  - If cnt == NDIG-1, go to DONE; otherwise cnt ← cnt+1.
- DONE → IDLE on out_ready. xs3_out and err hold their values until the next accept.
- conv_b = 4'b0000 in IDLE and DONE.
- start_valid outside IDLE is ignored; no job is queued.
- out_ready outside DONE is ignored.
- The arithmetic is in the converter: each XS-3 digit is BCD+3, 4-bit, with no carry between digits. The controller does no addition.
- Reset (rst_n low, any time including mid-CONV), immediately:
  - state=IDLE, cnt=0, operand=0, xs3_out=0, err=0.
  - out_valid=0, start_ready=1, busy=0, conv_b=0.
  - Any in-flight job is discarded.

## Timing
- Accept edge E0 (start_valid & start_ready high). After E0: state=CONV, cnt=0, start_ready=0, busy=1.
- Edge Ek (k=1..NDIG) captures result digit k-1.
- out_valid rises after edge E_NDIG: NDIG cycles after accept.
- Result handshake completes on the first edge with out_valid & out_ready.
  - After that edge: out_valid=0, busy=0, start_ready=1.
  - The next accept is possible one edge later.
  - Minimum job period is NDIG+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, xs3_out, err and out_valid are stable for an unbounded time.
- out_ready held high permanently gives a DONE residency of exactly 1 cycle.
- All outputs except conv_b are registered. conv_b is decoded from registered state, cnt and operand, with no combinational path from any input.
- NDIG=1: CONV lasts one cycle and cnt does not wrap.

## Test plan
- Reset, then bcd_in=16'h1234 with start_valid pulse, out_ready=1.
  - Expect conv_b sequence 4,3,2,1.
  - Expect out_valid 4 cycles after accept, xs3_out=16'h4567, err=4'b0000.
- bcd_in=16'h0999 → xs3_out=16'h3CCC, err=4'b0000.
- bcd_in=16'h9A05 → xs3_out=16'hC038, err=4'b0100. Digit 2 is forced to 0000 even if the converter model returns 4'hD.
- Backpressure: job 16'h5678, out_ready low for 5 cycles after out_valid.
  - xs3_out=16'h89AB stays stable.
  - start_ready=0; a start_valid with 16'h1111 during DONE is ignored.
  - Raise out_ready: IDLE next cycle, then 16'h1111 accepted and gives 16'h4444.
- Assert rst_n low mid-CONV (cnt=2) of job 16'h4321.
  - All outputs go to reset values immediately and no out_valid appears.
  - After release, job 16'h0000 → xs3_out=16'h3333.
- Back-to-back with start_valid and out_ready held high, 3 jobs: accepts are spaced exactly 6 cycles apart (NDIG+2).
